// File: rtl/pipe_stage_regs_pkg.sv
// Shared constants and types for the pipeline stage register slice.
package pipe_stage_regs_pkg;

  // Bit positions inside the 8-bit control bundle
  // {RegWrite, MemtoReg, MemWrite, ALUControl[2:0], ALUSrc, RegDst}
  localparam int CTRL_W        = 8;
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_ALU_HI   = 4;
  localparam int CTRL_ALU_LO   = 2;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_REGDST   = 0;

  // Execute-stage forward select encodings; 2'b11 falls back to the register value
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] PC_RESET  = 32'h0;

  // IF/ID payload
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } ifid_t;

  // ID/EX payload; an all-zero value is a bubble (RegWrite=MemWrite=0)
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       rd1;
    logic [31:0]       rd2;
    logic [31:0]       imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
  } idex_t;

  // Execute operand select: register file, writeback result or memory-stage ALU result
  function automatic logic [31:0] fwd_sel(input logic [1:0]  sel,
                                          input logic [31:0] reg_v,
                                          input logic [31:0] wb_v,
                                          input logic [31:0] mem_v);
    logic [31:0] r;
    case (sel)
      FWD_WB:  r = wb_v;
      FWD_MEM: r = mem_v;
      default: r = reg_v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage_regs_reg.sv
// Generic pipeline register: enable to load, synchronous clear to zero, async active-low reset.
module pipe_reg #(
  parameter int          W         = 32,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Hold when disabled; clear wins over load only when enabled, so a hold beats a flush
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_q <= RESET_VAL;
    else if (i_en) begin
      if (i_clr)      r_q <= '0;
      else            r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX registers with hazard controls, operand forwarding
// muxes and saturating stall/flush performance counters.
module pipe_stage_regs
  import pipe_stage_regs_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushE,
  input  logic        PCSrcD,
  input  logic [31:0] PCNextF,
  output logic [31:0] PCF,
  input  logic [31:0] InstrF,
  input  logic [31:0] PCPlus4F,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  input  logic [7:0]  CtrlD,
  output logic [7:0]  CtrlE,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  input  logic [31:0] SignImmD,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RdD,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] SignImmE,
  output logic [4:0]  RsE,
  output logic [4:0]  RtE,
  output logic [4:0]  RdE,
  input  logic        ForwardAD,
  input  logic        ForwardBD,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] ResultW,
  output logic [31:0] CmpAD,
  output logic [31:0] CmpBD,
  output logic [31:0] SrcAE,
  output logic [31:0] WriteDataE,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
);

  ifid_t       w_ifid_d, w_ifid_q;
  idex_t       w_idex_d, w_idex_q;
  logic        w_flush_evt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // ---------------- PC ----------------
  pipe_reg #(.W(32), .RESET_VAL(PC_RESET)) u_pc (
    .i_clk(Clk), .i_rst_n(Rst_n), .i_en(~StallF), .i_clr(1'b0),
    .i_d(PCNextF), .o_q(PCF)
  );

  // ---------------- IF/ID ----------------
  assign w_ifid_d = '{instr: InstrF, pcplus4: PCPlus4F};

  // Taken branch squashes the fetched instruction into a nop (NOP_INSTR is zero)
  pipe_reg #(.W($bits(ifid_t))) u_ifid (
    .i_clk(Clk), .i_rst_n(Rst_n), .i_en(~StallD), .i_clr(PCSrcD),
    .i_d(w_ifid_d), .o_q(w_ifid_q)
  );

  assign InstrD   = w_ifid_q.instr;
  assign PCPlus4D = w_ifid_q.pcplus4;

  // ---------------- ID/EX ----------------
  assign w_idex_d = '{ctrl: CtrlD, rd1: RD1D, rd2: RD2D, imm: SignImmD,
                      rs: RsD, rt: RtD, rd: RdD};

  // Never holds; a flush loads an all-zero bubble
  pipe_reg #(.W($bits(idex_t))) u_idex (
    .i_clk(Clk), .i_rst_n(Rst_n), .i_en(1'b1), .i_clr(FlushE),
    .i_d(w_idex_d), .o_q(w_idex_q)
  );

  assign CtrlE    = w_idex_q.ctrl;
  assign RD1E     = w_idex_q.rd1;
  assign RD2E     = w_idex_q.rd2;
  assign SignImmE = w_idex_q.imm;
  assign RsE      = w_idex_q.rs;
  assign RtE      = w_idex_q.rt;
  assign RdE      = w_idex_q.rd;

  // ---------------- Forwarding ----------------
  assign CmpAD      = ForwardAD ? ALUOutM : RD1D;
  assign CmpBD      = ForwardBD ? ALUOutM : RD2D;
  assign SrcAE      = fwd_sel(ForwardAE, RD1E, ResultW, ALUOutM);
  assign WriteDataE = fwd_sel(ForwardBE, RD2E, ResultW, ALUOutM);

  // ---------------- Performance counters ----------------
  // A stalled decode suppresses the branch flush, so it is not counted either
  assign w_flush_evt = FlushE | (PCSrcD & ~StallD);

  // Saturating stall counter; assigned every cycle so it always tracks its next value
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                                  r_stall_cnt <= '0;
    else if (StallD && (r_stall_cnt != '1))      r_stall_cnt <= r_stall_cnt + 32'd1;
    else                                         r_stall_cnt <= r_stall_cnt;
  end

  // Saturating flush counter; one count per cycle even when both flush sources fire
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                                  r_flush_cnt <= '0;
    else if (w_flush_evt && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 32'd1;
    else                                         r_flush_cnt <= r_flush_cnt;
  end

  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed self-checking bench for pipe_stage_regs.
module tb_pipe_stage_regs;

  logic        Clk, Rst_n;
  logic        StallF, StallD, FlushE, PCSrcD;
  logic [31:0] PCNextF, PCF, InstrF, PCPlus4F, InstrD, PCPlus4D;
  logic [7:0]  CtrlD, CtrlE;
  logic [31:0] RD1D, RD2D, SignImmD, RD1E, RD2E, SignImmE;
  logic [4:0]  RsD, RtD, RdD, RsE, RtE, RdE;
  logic        ForwardAD, ForwardBD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ALUOutM, ResultW, CmpAD, CmpBD, SrcAE, WriteDataE;
  logic [31:0] StallCount, FlushCount;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_regs dut (
    .Clk(Clk), .Rst_n(Rst_n), .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .PCSrcD(PCSrcD), .PCNextF(PCNextF), .PCF(PCF), .InstrF(InstrF),
    .PCPlus4F(PCPlus4F), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .CtrlD(CtrlD),
    .CtrlE(CtrlE), .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD), .RsD(RsD),
    .RtD(RtD), .RdD(RdD), .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
    .RsE(RsE), .RtE(RtE), .RdE(RdE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ALUOutM(ALUOutM),
    .ResultW(ResultW), .CmpAD(CmpAD), .CmpBD(CmpBD), .SrcAE(SrcAE),
    .WriteDataE(WriteDataE), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // advance one rising edge and settle just after it
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    StallF = 0; StallD = 0; FlushE = 0; PCSrcD = 0;
    PCNextF = 32'h40; InstrF = 32'hDEADBEEF; PCPlus4F = 32'h44; CtrlD = 8'hFF;
    step();
    @(negedge Clk);
    StallF = 1; StallD = 1;
    step();
    n_tests++; if (PCF !== 32'h40) begin n_fail++; $display("FAIL pre_reset_pcf got %h exp %h", PCF, 32'h40); end
    n_tests++; if (InstrD !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pre_reset_instrd got %h exp %h", InstrD, 32'hDEADBEEF); end
    n_tests++; if (StallCount !== 32'd1) begin n_fail++; $display("FAIL pre_reset_stallcnt got %0d exp 1", StallCount); end
    #2 Rst_n = 0;  // mid-cycle, asynchronous
    #1;
    n_tests++; if (PCF !== 32'h0) begin n_fail++; $display("FAIL reset_pcf got %h exp 0", PCF); end
    n_tests++; if (InstrD !== 32'h0) begin n_fail++; $display("FAIL reset_instrd got %h exp 0", InstrD); end
    n_tests++; if (CtrlE !== 8'h0) begin n_fail++; $display("FAIL reset_ctrle got %h exp 0", CtrlE); end
    n_tests++; if (StallCount !== 32'h0 || FlushCount !== 32'h0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d exp 0/0", StallCount, FlushCount); end
    @(negedge Clk);
    Rst_n = 1; StallF = 0; StallD = 0;
    PCNextF = 0; InstrF = 0; PCPlus4F = 0; CtrlD = 0;
  endtask

  task automatic test_load_use();
    @(negedge Clk);
    PCNextF = 32'h44; InstrF = 32'h8C080004; CtrlD = 8'hA5;
    step();
    n_tests++; if (InstrD !== 32'h8C080004 || CtrlE !== 8'hA5) begin n_fail++; $display("FAIL lu_load got %h/%h exp 8c080004/a5", InstrD, CtrlE); end
    @(negedge Clk);
    StallF = 1; StallD = 1; FlushE = 1;
    PCNextF = 32'h48; InstrF = 32'h12345678;
    step();
    n_tests++; if (PCF !== 32'h44) begin n_fail++; $display("FAIL lu_pcf got %h exp 44", PCF); end
    n_tests++; if (InstrD !== 32'h8C080004) begin n_fail++; $display("FAIL lu_instrd got %h exp 8c080004", InstrD); end
    n_tests++; if (CtrlE !== 8'h0) begin n_fail++; $display("FAIL lu_ctrle got %h exp 0", CtrlE); end
    n_tests++; if (StallCount !== 32'd1 || FlushCount !== 32'd1) begin n_fail++; $display("FAIL lu_counters got %0d/%0d exp 1/1", StallCount, FlushCount); end
    @(negedge Clk);
    StallF = 0; StallD = 0; FlushE = 0; CtrlD = 0;
  endtask

  task automatic test_branch();
    @(negedge Clk);
    PCSrcD = 1; InstrF = 32'h01095020; PCPlus4F = 32'h50;
    step();
    n_tests++; if (InstrD !== 32'h0 || PCPlus4D !== 32'h0) begin n_fail++; $display("FAIL br_flush got %h/%h exp 0/0", InstrD, PCPlus4D); end
    n_tests++; if (FlushCount !== 32'd2) begin n_fail++; $display("FAIL br_flushcnt got %0d exp 2", FlushCount); end
    @(negedge Clk);
    PCSrcD = 0;
    step();
    n_tests++; if (InstrD !== 32'h01095020 || PCPlus4D !== 32'h50) begin n_fail++; $display("FAIL br_load got %h/%h exp 01095020/50", InstrD, PCPlus4D); end
    @(negedge Clk);
    PCSrcD = 1; StallD = 1; InstrF = 32'hCAFEF00D;
    step();
    n_tests++; if (InstrD !== 32'h01095020) begin n_fail++; $display("FAIL br_stall_hold got %h exp 01095020", InstrD); end
    n_tests++; if (StallCount !== 32'd2 || FlushCount !== 32'd2) begin n_fail++; $display("FAIL br_stall_counters got %0d/%0d exp 2/2", StallCount, FlushCount); end
    @(negedge Clk);
    PCSrcD = 1; StallD = 0; FlushE = 1;  // both flush sources in one cycle
    step();
    n_tests++; if (FlushCount !== 32'd3) begin n_fail++; $display("FAIL br_both_once got %0d exp 3", FlushCount); end
    @(negedge Clk);
    PCSrcD = 0; FlushE = 0;
  endtask

  task automatic test_fwd_exec();
    logic [1:0]  sel [4];
    logic [31:0] exp_a [4];
    logic [31:0] exp_b [4];
    sel = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp_a = '{32'h11, 32'h33, 32'h22, 32'h11};
    exp_b = '{32'h44, 32'h33, 32'h22, 32'h44};
    @(negedge Clk);
    RD1D = 32'h11; RD2D = 32'h44; SignImmD = 32'hFFFF_FFF0;
    RsD = 5'd3; RtD = 5'd4; RdD = 5'd5; CtrlD = 8'h82;
    step();
    n_tests++; if (RsE !== 5'd3 || RtE !== 5'd4 || RdE !== 5'd5 || SignImmE !== 32'hFFFF_FFF0 || CtrlE !== 8'h82)
      begin n_fail++; $display("FAIL ex_load got rs=%0d rt=%0d rd=%0d imm=%h ctrl=%h", RsE, RtE, RdE, SignImmE, CtrlE); end
    ALUOutM = 32'h22; ResultW = 32'h33;
    for (int i = 0; i < 4; i++) begin
      ForwardAE = sel[i]; ForwardBE = sel[i];
      #1;
      n_tests++; if (SrcAE !== exp_a[i]) begin n_fail++; $display("FAIL fwd_srcae sel=%b got %h exp %h", sel[i], SrcAE, exp_a[i]); end
      n_tests++; if (WriteDataE !== exp_b[i]) begin n_fail++; $display("FAIL fwd_wdatae sel=%b got %h exp %h", sel[i], WriteDataE, exp_b[i]); end
    end
    ForwardAE = 0; ForwardBE = 0;
    @(negedge Clk);
    FlushE = 1;
    step();
    n_tests++; if (RD1E !== 0 || RD2E !== 0 || RsE !== 0 || SignImmE !== 0 || CtrlE !== 0)
      begin n_fail++; $display("FAIL ex_bubble got rd1=%h rd2=%h rs=%0d ctrl=%h", RD1E, RD2E, RsE, CtrlE); end
    @(negedge Clk);
    FlushE = 0;
  endtask

  task automatic test_fwd_decode();
    @(negedge Clk);
    RD1D = 32'h7; RD2D = 32'h5; ALUOutM = 32'h9;
    ForwardBD = 1; ForwardAD = 0;
    #1;
    n_tests++; if (CmpBD !== 32'h9) begin n_fail++; $display("FAIL cmpbd_fwd got %h exp 9", CmpBD); end
    n_tests++; if (CmpAD !== 32'h7) begin n_fail++; $display("FAIL cmpad_reg got %h exp 7", CmpAD); end
    ForwardBD = 0; ForwardAD = 1;
    #1;
    n_tests++; if (CmpBD !== 32'h5) begin n_fail++; $display("FAIL cmpbd_reg got %h exp 5", CmpBD); end
    n_tests++; if (CmpAD !== 32'h9) begin n_fail++; $display("FAIL cmpad_fwd got %h exp 9", CmpAD); end
    ForwardAD = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [3];
    ins = '{32'h20080001, 32'h20090002, 32'h01095020};
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      InstrF = ins[i]; PCNextF = 32'h100 + 32'(i * 4); RD1D = 32'(i + 1);
      step();
      n_tests++; if (InstrD !== ins[i] || PCF !== 32'h100 + 32'(i * 4) || RD1E !== 32'(i + 1))
        begin n_fail++; $display("FAIL b2b_%0d got instr=%h pc=%h rd1e=%h", i, InstrD, PCF, RD1E); end
    end
  endtask

  task automatic test_saturation();
    @(negedge Clk);
    StallD = 1; StallF = 1;
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1 release dut.r_stall_cnt;
    #1;
    n_tests++; if (StallCount !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sat_preload got %h exp fffffffe", StallCount); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (StallCount !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_cycle%0d got %h exp ffffffff", i, StallCount); end
    end
    // reset while stalled discards the held instruction
    #2 Rst_n = 0;
    @(negedge Clk);
    Rst_n = 1; StallD = 0; StallF = 0; InstrF = 32'h0;
    #1;
    n_tests++; if (InstrD !== 32'h0 || StallCount !== 32'h0) begin n_fail++; $display("FAIL reset_mid_stall got %h/%h exp 0/0", InstrD, StallCount); end
  endtask

  initial begin
    Rst_n = 0; StallF = 0; StallD = 0; FlushE = 0; PCSrcD = 0;
    PCNextF = 0; InstrF = 0; PCPlus4F = 0; CtrlD = 0;
    RD1D = 0; RD2D = 0; SignImmD = 0; RsD = 0; RtD = 0; RdD = 0;
    ForwardAD = 0; ForwardBD = 0; ForwardAE = 0; ForwardBE = 0;
    ALUOutM = 0; ResultW = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1;
    test_reset();
    test_load_use();
    test_branch();
    test_fwd_exec();
    test_fwd_decode();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_regs.md
PIPE_STAGE_REGS -- requirements
Module: pipe_stage_regs

Interface
REQ-001 SHALL have port: Clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port: Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: StallF  input  1  hold PC register.
REQ-004 SHALL have port: StallD  input  1  hold IF/ID register.
REQ-005 SHALL have port: FlushE  input  1  insert bubble into ID/EX register.
REQ-006 SHALL have port: PCSrcD  input  1  branch taken in decode; flush IF/ID.
REQ-007 SHALL have port: PCNextF  input  32  next PC; PCF  output  32  current PC.
REQ-008 SHALL have ports: InstrF, PCPlus4F  input  32 each; InstrD, PCPlus4D  output  32 each.
REQ-009 SHALL have ports: CtrlD  input  8 and CtrlE  output  8, packed as {RegWrite, MemtoReg, MemWrite, ALUControl[2:0], ALUSrc, RegDst}.
REQ-010 SHALL have ports: RD1D, RD2D, SignImmD  input  32 each; RsD, RtD, RdD  input  5 each; matching E-suffixed outputs.
REQ-011 SHALL have ports: ForwardAD, ForwardBD  input  1; ForwardAE, ForwardBE  input  2; ALUOutM, ResultW  input  32.
REQ-012 SHALL have ports: CmpAD, CmpBD  output  32 branch-compare operands; SrcAE, WriteDataE  output  32 forwarded execute operands.
REQ-013 SHALL have ports: StallCount, FlushCount  output  32 performance counters.

Function
REQ-014 PC: StallF=1 -> PCF holds; else PCF <= PCNextF.
REQ-015 IF/ID: StallD=1 -> hold (stall beats PCSrcD); else PCSrcD=1 -> InstrD, PCPlus4D <= 0 (nop); else load F values.
REQ-016 ID/EX: FlushE=1 -> all E outputs <= 0 (CtrlE=0 gives RegWrite=MemWrite=0 bubble); else load D values; no stall input, ID/EX never holds.
REQ-017 Decode forwarding, combinational: CmpAD = ForwardAD ? ALUOutM : RD1D; CmpBD = ForwardBD ? ALUOutM : RD2D.
REQ-018 Execute forwarding, combinational: 00 -> RD1E/RD2E, 01 -> ResultW, 10 -> ALUOutM, 11 -> treated as 00; SrcAE from ForwardAE, WriteDataE from ForwardBE.
REQ-019 StallCount increments by 1 per cycle with StallD=1; saturates at 0xFFFFFFFF.
REQ-020 FlushCount increments by 1 per cycle with FlushE=1 or (PCSrcD=1 and StallD=0); a cycle with both counts once; saturates.
REQ-021 Latency: F->D and D->E one cycle each; forwarding outputs zero-cycle.
REQ-022 No X propagation: every register has a defined reset value.

Reset
REQ-023 Rst_n=0 SHALL immediately force PCF=0x00000000, all D and E registers=0, both counters=0, regardless of Clk.
REQ-024 Reset release SHALL take effect at the first rising Clk edge with Rst_n=1; a reset mid-stall discards the held state.

Structure
REQ-025 Shared package SHALL hold: Ctrl bit-position constants, forward-select encodings (FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10), NOP_INSTR=32'h0, PC_RESET=32'h0.
REQ-026 One sub-module pipe_reg (parameterised width, en, clr, async active-low reset) SHALL be instantiated for PC, IF/ID and ID/EX.

Verification
REQ-027 Reset: Rst_n=0 mid-cycle with PCF=0x40 -> PCF, InstrD, CtrlE, counters read 0 before next edge.
REQ-028 Load-use stall: StallF=StallD=FlushE=1 for 1 cycle, InstrD=0x8C080004 -> PCF and InstrD unchanged, CtrlE=0, StallCount=1, FlushCount=1.
REQ-029 Branch flush: PCSrcD=1, StallD=0, InstrF=0x01095020 -> next InstrD=0, FlushCount+1; with StallD=1 as well -> InstrD held, StallCount+1.
REQ-030 Forwarding: RD1E=0x11, ALUOutM=0x22, ResultW=0x33; ForwardAE=00/01/10/11 -> SrcAE=0x11/0x33/0x22/0x11.
REQ-031 Decode forwarding: ForwardBD=1, RD2D=0x5, ALUOutM=0x9 -> CmpBD=0x9; ForwardBD=0 -> 0x5.
REQ-032 Saturation: force StallCount to 0xFFFFFFFE, hold StallD=1 for 3 cycles -> StallCount=0xFFFFFFFF, no wrap.
